// File: rtl/systolic_seq_ctrl_if.sv
// Host/array handshake bundle for the systolic sequencer.
// master = sequencer side, slave = host, skew buffers and result consumer.
interface systolic_seq_ctrl_if #(
   parameter int DIM   = 8,
   parameter int ROW_W = $clog2(DIM)
);
   logic             start;
   logic             busy;
   logic             done;
   logic             c_wr_en;
   logic [ROW_W-1:0] c_row;
   logic             feed_vld;
   logic [ROW_W-1:0] feed_k;
   logic             op_valid;
   logic             mac_en;
   logic             rd_vld;
   logic             rd_rdy;

   modport master (
      input  start, op_valid, rd_rdy,
      output busy, done, c_wr_en, c_row, feed_vld, feed_k, mac_en, rd_vld
   );

   modport slave (
      output start, op_valid, rd_rdy,
      input  busy, done, c_wr_en, c_row, feed_vld, feed_k, mac_en, rd_vld
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIM x DIM tpumac systolic array: clear, feed/drain, read, done.
// Define SYS_SEQ_PERF_EN to add the saturating perf_stall_cnt output.
module systolic_seq_ctrl #(
   parameter int DIM   = 8,
   parameter int ROW_W = $clog2(DIM),
   parameter int CC_W  = $clog2(3*DIM)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef SYS_SEQ_PERF_EN
   output logic [15:0]           perf_stall_cnt,
`endif
   systolic_seq_ctrl_if.master   bus
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);
   localparam logic [CC_W-1:0]  CC_FEED  = CC_W'(DIM);
   localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(3*DIM - 3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_COMPUTE,
      S_READ,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [CC_W-1:0]  cc_q, cc_d;
   logic             feed_vld;
   logic             mac_en;

`ifdef SYS_SEQ_PERF_EN
   logic [15:0]      stall_cnt_q, stall_cnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cc_d     = cc_q;
      feed_vld = (state_q == S_COMPUTE) && (cc_q < CC_FEED);
      // Only a missing operand beat freezes the array; the drain never waits.
      mac_en   = (state_q == S_COMPUTE) && !(feed_vld && !bus.op_valid);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CLEAR;
               row_d   = '0;
            end
         end
         S_CLEAR: begin
            if (row_q == ROW_LAST) begin
               state_d = S_COMPUTE;
               row_d   = '0;
               cc_d    = '0;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         S_COMPUTE: begin
            if (mac_en) begin
               if (cc_q == CC_LAST) begin
                  state_d = S_READ;
                  row_d   = '0;
                  cc_d    = '0;
               end else begin
                  cc_d = cc_q + 1'b1;
               end
            end
         end
         S_READ: begin
            if (bus.rd_rdy) begin
               if (row_q == ROW_LAST) begin
                  state_d = S_DONE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SYS_SEQ_PERF_EN
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == S_IDLE && bus.start) begin
         stall_cnt_d = '0;
      end else if (state_q == S_COMPUTE && !mac_en && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         cc_q        <= '0;
`ifdef SYS_SEQ_PERF_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         cc_q        <= cc_d;
`ifdef SYS_SEQ_PERF_EN
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

   // row_q is zero outside CLEAR/READ, so it can drive c_row directly.
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.c_wr_en  = (state_q == S_CLEAR);
   assign bus.c_row    = row_q;
   assign bus.feed_vld = feed_vld;
   assign bus.feed_k   = feed_vld ? cc_q[ROW_W-1:0] : '0;
   assign bus.mac_en   = mac_en;
   assign bus.rd_vld   = (state_q == S_READ);

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl at DIM=4: per-cycle timelines written by hand.
module tb_systolic_seq_ctrl;
   localparam int DIM   = 4;
   localparam int ROW_W = $clog2(DIM);

   logic clk = 1'b0;
   logic rst;
`ifdef SYS_SEQ_PERF_EN
   logic [15:0] perf_stall_cnt;
`endif

   systolic_seq_ctrl_if #(.DIM(DIM), .ROW_W(ROW_W)) bus ();

   systolic_seq_ctrl #(.DIM(DIM)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef SYS_SEQ_PERF_EN
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_mac;

   // Expected timelines, bit/entry c = value during the cycle after edge c-1.
   logic [63:0] m_busy, m_done, m_wr, m_feed, m_mac, m_rd;
   logic [63:0] m_start, m_opv, m_rdy, m_rst;
   int          e_row [64];
   int          e_k   [64];

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int a, input int b);
      logic [63:0] m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic clr_exp();
      m_busy = '0; m_done = '0; m_wr = '0; m_feed = '0; m_mac = '0; m_rd = '0;
      m_start = '0; m_rst = '0; m_opv = '1; m_rdy = '1;
      for (int i = 0; i < 64; i++) begin
         e_row[i] = 0;
         e_k[i]   = 0;
      end
   endtask

   // step=1 gives a ramp from v0, step=0 a held value.
   task automatic seq(input bit is_k, input int a, input int b, input int v0, input int step);
      for (int c = a; c <= b; c++) begin
         if (is_k) e_k[c] = v0 + (c - a) * step;
         else      e_row[c] = v0 + (c - a) * step;
      end
   endtask

   // Unstalled operation whose start is sampled at edge o.
   task automatic load_nominal(input int o);
      m_start |= rng(o, o);
      m_busy  |= rng(o + 1, o + 19);
      m_done  |= rng(o + 19, o + 19);
      m_wr    |= rng(o + 1, o + 4);
      m_feed  |= rng(o + 5, o + 8);
      m_mac   |= rng(o + 5, o + 14);
      m_rd    |= rng(o + 15, o + 18);
      seq(1'b0, o + 1, o + 4, 0, 1);
      seq(1'b1, o + 5, o + 8, 0, 1);
      seq(1'b0, o + 15, o + 18, 0, 1);
   endtask

   // Entered and left at posedge+1; inputs applied, then outputs sampled 1ns later.
   task automatic run_vec(input string tag, input int ncyc);
      n_mac = 0;
      for (int c = 0; c <= ncyc; c++) begin
         bus.start    = m_start[c];
         bus.op_valid = m_opv[c];
         bus.rd_rdy   = m_rdy[c];
         rst          = m_rst[c];
         #1;
         chk($sformatf("%s.busy@%0d", tag, c),     int'(bus.busy),     int'(m_busy[c]));
         chk($sformatf("%s.done@%0d", tag, c),     int'(bus.done),     int'(m_done[c]));
         chk($sformatf("%s.c_wr_en@%0d", tag, c),  int'(bus.c_wr_en),  int'(m_wr[c]));
         chk($sformatf("%s.feed_vld@%0d", tag, c), int'(bus.feed_vld), int'(m_feed[c]));
         chk($sformatf("%s.mac_en@%0d", tag, c),   int'(bus.mac_en),   int'(m_mac[c]));
         chk($sformatf("%s.rd_vld@%0d", tag, c),   int'(bus.rd_vld),   int'(m_rd[c]));
         chk($sformatf("%s.c_row@%0d", tag, c),    int'(bus.c_row),    e_row[c]);
         chk($sformatf("%s.feed_k@%0d", tag, c),   int'(bus.feed_k),   e_k[c]);
         chk($sformatf("%s.excl@%0d", tag, c),
             (int'(bus.c_wr_en) + int'(bus.mac_en) + int'(bus.rd_vld) <= 1) ? 1 : 0, 1);
         if (bus.mac_en) n_mac++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.op_valid = 1'b1;
      bus.rd_rdy   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy",     int'(bus.busy),     0);
      chk("reset.done",     int'(bus.done),     0);
      chk("reset.c_wr_en",  int'(bus.c_wr_en),  0);
      chk("reset.feed_vld", int'(bus.feed_vld), 0);
      chk("reset.mac_en",   int'(bus.mac_en),   0);
      chk("reset.rd_vld",   int'(bus.rd_vld),   0);
      chk("reset.c_row",    int'(bus.c_row),    0);
      chk("reset.feed_k",   int'(bus.feed_k),   0);
`ifdef SYS_SEQ_PERF_EN
      chk("reset.perf", int'(perf_stall_cnt), 0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Nominal run
      clr_exp();
      load_nominal(0);
      run_vec("nominal", 22);
      chk("nominal.compute_len", n_mac, 10);
`ifdef SYS_SEQ_PERF_EN
      chk("nominal.perf", int'(perf_stall_cnt), 0);
`endif

      // Operand stall: op_valid low on cycles 7-9 while feed_k=2
      clr_exp();
      m_start = rng(0, 0);
      m_opv   = ~rng(7, 9);
      m_busy  = rng(1, 22);
      m_done  = rng(22, 22);
      m_wr    = rng(1, 4);
      m_feed  = rng(5, 11);
      m_mac   = rng(5, 6) | rng(10, 17);
      m_rd    = rng(18, 21);
      seq(1'b0, 1, 4, 0, 1);
      seq(1'b1, 5, 7, 0, 1);
      seq(1'b1, 8, 10, 2, 0);
      seq(1'b1, 11, 11, 3, 0);
      seq(1'b0, 18, 21, 0, 1);
      run_vec("stall", 25);
      chk("stall.mac_steps", n_mac, 10);
`ifdef SYS_SEQ_PERF_EN
      chk("stall.perf_held", int'(perf_stall_cnt), 3);
`endif

      // Result backpressure: rd_rdy low on cycles 16-17 at c_row=1
      clr_exp();
      m_start = rng(0, 0);
      m_rdy   = ~rng(16, 17);
      m_busy  = rng(1, 21);
      m_done  = rng(21, 21);
      m_wr    = rng(1, 4);
      m_feed  = rng(5, 8);
      m_mac   = rng(5, 14);
      m_rd    = rng(15, 20);
      seq(1'b0, 1, 4, 0, 1);
      seq(1'b1, 5, 8, 0, 1);
      seq(1'b0, 15, 15, 0, 0);
      seq(1'b0, 16, 18, 1, 0);
      seq(1'b0, 19, 20, 2, 1);
      run_vec("backpr", 23);
      chk("backpr.compute_len", n_mac, 10);

      // Reset during COMPUTE at cc=5 (cycle 10), then a clean nominal run
      clr_exp();
      load_nominal(0);
      m_busy &= rng(0, 10);
      m_done &= rng(0, 10);
      m_wr   &= rng(0, 10);
      m_feed &= rng(0, 10);
      m_mac  &= rng(0, 10);
      m_rd   &= rng(0, 10);
      for (int c = 11; c < 64; c++) begin
         e_row[c] = 0;
         e_k[c]   = 0;
      end
      m_rst = rng(10, 10);
      run_vec("midrst", 13);
`ifdef SYS_SEQ_PERF_EN
      chk("midrst.perf", int'(perf_stall_cnt), 0);
`endif
      clr_exp();
      load_nominal(0);
      run_vec("postrst", 21);
      chk("postrst.compute_len", n_mac, 10);

      // start held high across a whole run including DONE
      clr_exp();
      load_nominal(0);
      load_nominal(20);
      m_start = rng(0, 39);
      run_vec("hold_start", 43);
      chk("hold_start.mac_steps", n_mac, 20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for a DIM x DIM systolic array of tpumac cells computing C = A x B.
- Steps the array through four phases: clear accumulators, stream DIM skewed operand beats, drain the wavefront, read results row by row.
- Drives the array-wide en/WrEn and the operand/result buffer handshakes. Sits between the host command interface and the array plus its skew buffers.

Parameters:
- DIM, 8, array dimension (rows = columns = operand beats); legal range 2..64.
- ROW_W, $clog2(DIM), width of row/beat indices.
- CC_W, $clog2(3*DIM), width of the compute cycle counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin one matrix operation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse in DONE state.
- c_wr_en  out  1  to array WrEn; loads Cin (zero, supplied externally) into row c_row.
- c_row  out  ROW_W  row index for accumulator clear and result read.
- feed_vld  out  1  operand beat request to A/B skew buffers.
- feed_k  out  ROW_W  operand beat index (A column k / B row k).
- op_valid  in  1  skew buffers have beat feed_k available.
- mac_en  out  1  to array en; advances every MAC cell one step.
- rd_vld  out  1  result row c_row presented on array Cout bus.
- rd_rdy  in  1  result consumer accepts row.

Behaviour:
- Reset (any state, including mid-operation): state=IDLE, all counters 0, busy=done=c_wr_en=feed_vld=mac_en=rd_vld=0, c_row=feed_k=0.
- All outputs are registered-state decodes, except mac_en, which is combinational on op_valid.
- IDLE:
  - start=1 at posedge -> CLEAR next cycle.
  - start while busy is ignored; it is not queued.
- CLEAR:
  - c_wr_en=1, c_row = 0..DIM-1 on consecutive cycles (DIM cycles).
  - After row DIM-1 -> COMPUTE with cc=0.
- COMPUTE:
  - feed_vld = (cc < DIM); feed_k = cc while feed_vld, else 0.
  - mac_en = !(feed_vld && !op_valid).
  - cc increments only when mac_en=1.
  - Stall (feed_vld=1, op_valid=0): mac_en=0; cc and feed_k hold; the array freezes.
  - After feeding (cc >= DIM), op_valid is ignored and mac_en=1 for the drain.
  - Leaves when cc == 3*DIM-3 with mac_en=1 -> READ with r=0.
  - Unstalled length: exactly 3*DIM-2 cycles.
- READ:
  - rd_vld=1, c_row=r.
  - r advances only on rd_vld && rd_rdy.
  - Accepting r=DIM-1 -> DONE.
  - rd_rdy low holds c_row stable indefinitely.
- DONE: done=1 and busy=1 for one cycle -> IDLE.
  - start asserted in DONE is ignored.
  - start in the following IDLE cycle is accepted.
- Exclusivity invariants: c_wr_en, mac_en and rd_vld are never high together; feed_vld implies state COMPUTE.
- Counter wrap: none. All counters are reset on phase entry and bounded by DIM-1 or 3*DIM-3.

Optional Feature:
- Macro SYS_SEQ_PERF_EN.
- When defined:
  - Adds output perf_stall_cnt [15:0], counting COMPUTE cycles with mac_en=0.
  - Saturates at 16'hFFFF.
  - Cleared on rst and on IDLE->CLEAR; holds its value after done.
- When undefined:
  - Port and counter are absent.
  - Behaviour is otherwise identical.

Test Plan (DIM=4, op_valid=1, rd_rdy=1 unless stated):
1. Nominal run. Stimulus: start pulsed at edge 0. Required response:
   - c_wr_en cycles 1-4 with c_row 0,1,2,3.
   - mac_en cycles 5-14, with feed_vld/feed_k 0..3 on cycles 5-8.
   - rd_vld cycles 15-18 with c_row 0..3.
   - done=1 on cycle 19 only; busy=0 from cycle 20.
2. Operand stall. Stimulus: op_valid=0 for 3 cycles when feed_k=2. Required response:
   - mac_en=0 and feed_k=2 held for those 3 cycles.
   - done moves to cycle 22.
   - perf_stall_cnt=3 (with SYS_SEQ_PERF_EN).
3. Result backpressure. Stimulus: rd_rdy=0 for 2 cycles at c_row=1. Required response: c_row=1 held, rd_vld stays 1, done on cycle 21.
4. Reset mid-op. Stimulus: rst=1 during COMPUTE at cc=5. Required response:
   - Next cycle: IDLE, all outputs 0.
   - A new start gives the nominal timing of scenario 1.
5. Spurious start. Stimulus: start held high throughout a run, including DONE. Required response:
   - Exactly one operation runs for each IDLE acceptance.
   - The next operation begins CLEAR on the cycle after IDLE is entered.
6. Invariant check. Throughout scenarios 1-5, assert:
   - c_wr_en, mac_en and rd_vld are never high together.
   - The unstalled COMPUTE length is 10 cycles.
